// File: rtl/labft_fault_manager.sv
// labft_fault_manager: classifies LABFT row-check failures as transient or
// permanent. A failing check flushes the checker's accumulators, then asks
// the host to re-run the tile. Too many consecutive failures raise irq.
module labft_fault_manager #(
  parameter int arraySize   = 4,
  parameter int maxRetries  = 2,
  parameter int flushCycles = 2,
  parameter int countBits   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 check_valid,
  input  logic [arraySize-1:0] error,
  input  logic                 retry_ack,
  input  logic                 clear_fault,
  output logic                 interrupt,
  output logic                 retry_req,
  output logic                 irq,
  output logic [arraySize-1:0] sticky_error,
  output logic [arraySize-1:0] last_error,
  output logic [countBits-1:0] fault_count
);

  // retry_cnt must be able to hold maxRetries+1, the value that trips FAULT.
  localparam int RetryW = $clog2(maxRetries + 2);
  localparam int FlushW = (flushCycles > 1) ? $clog2(flushCycles) : 1;
  localparam logic [RetryW-1:0] MaxRetriesV = RetryW'(maxRetries);
  localparam logic [FlushW-1:0] FlushInitV  = FlushW'(flushCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RETRY = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e               state_q;
  logic [RetryW-1:0]    retry_cnt_q;
  logic [FlushW-1:0]    flush_cnt_q;
  logic                 interrupt_q;
  logic                 retry_req_q;
  logic                 irq_q;
  logic [arraySize-1:0] sticky_q;
  logic [arraySize-1:0] last_q;
  logic [countBits-1:0] count_q;

  // A failing result is only acted on while waiting for a check.
  logic                 fail_accept;
  logic [RetryW-1:0]    retry_cnt_inc;
  logic [arraySize-1:0] sticky_base;
  logic [countBits-1:0] count_base;
  logic [countBits-1:0] count_d;

  assign fail_accept   = (state_q == IDLE) && check_valid && (error != '0);
  assign retry_cnt_inc = retry_cnt_q + 1'b1;
  // clear_fault applies before a coincident failing check is folded in.
  assign sticky_base   = clear_fault ? '0 : sticky_q;
  assign count_base    = clear_fault ? '0 : count_q;
  assign count_d       = (count_base == '1) ? count_base : count_base + 1'b1;

  // Diagnostic registers: sticky/last error vectors and saturating count.
  // NOTE: every register here is async-reset and assigned with <= only, so
  // all outputs drop to 0 the moment rst falls and no ordering races exist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
      last_q   <= '0;
      count_q  <= '0;
    end else if (fail_accept) begin
      last_q   <= error;
      sticky_q <= sticky_base | error;
      count_q  <= count_d;
    end else if (clear_fault) begin
      sticky_q <= '0;
      last_q   <= '0;
      count_q  <= '0;
    end
  end

  // Recovery FSM with registered interrupt / retry_req / irq outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      retry_cnt_q <= '0;
      flush_cnt_q <= '0;
      interrupt_q <= 1'b0;
      retry_req_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (check_valid) begin
            if (error == '0) begin
              retry_cnt_q <= '0;
            end else begin
              retry_cnt_q <= retry_cnt_inc;
              if (retry_cnt_inc > MaxRetriesV) begin
                state_q <= FAULT;
                irq_q   <= 1'b1;
              end else begin
                state_q     <= FLUSH;
                interrupt_q <= 1'b1;
                flush_cnt_q <= FlushInitV;
              end
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_q     <= RETRY;
            interrupt_q <= 1'b0;
            retry_req_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        RETRY: begin
          // retry_cnt is kept so the re-executed check counts toward the limit.
          if (retry_ack) begin
            state_q     <= IDLE;
            retry_req_q <= 1'b0;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state_q     <= IDLE;
            irq_q       <= 1'b0;
            retry_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign interrupt    = interrupt_q;
  assign retry_req    = retry_req_q;
  assign irq          = irq_q;
  assign sticky_error = sticky_q;
  assign last_error   = last_q;
  assign fault_count  = count_q;

endmodule
